// File: rtl/fir_ctrl_fsm_param.sv
// Load/compute control for a ping-pong-bank FIR. Output valid NUM_READS+4 cycles after iEnSample.
// Coefficients use a valid/ready handshake. Samples that arrive while busy are dropped and counted.
module fir_ctrl_fsm_param #(
  parameter int NUM_TAPS = 33,
  parameter int NUM_MAC  = 3,
  parameter int ADDR_W   = 4,
  localparam int MSEL_W  = (NUM_MAC > 1) ? $clog2(NUM_MAC) : 1
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iUpdateFlag,
  input  logic              iCoeffValid,
  output logic              oCoeffReady,
  input  logic              iEnSample,
  output logic              oWrCsn,
  output logic              oWrBank,
  output logic [MSEL_W-1:0] oWrMacSel,
  output logic [ADDR_W-1:0] oWrAddr,
  output logic              oWrZero,
  output logic              oRdCsn,
  output logic              oRdBank,
  output logic [ADDR_W-1:0] oRdAddr,
  output logic              oMacClr,
  output logic              oMacEn,
  output logic              oAccEn,
  output logic              oEnOut,
  output logic              oBusy,
  output logic              oCoeffValid,
  output logic              oOverrun,
  output logic [7:0]        oOverrunCnt
);

  localparam int NUM_READS = (NUM_TAPS + NUM_MAC - 1) / NUM_MAC;
  localparam int NUM_SLOTS = NUM_MAC * NUM_READS;
  localparam int IDX_W     = $clog2(NUM_SLOTS);
  localparam logic [IDX_W-1:0]  LAST_TAP  = IDX_W'(NUM_TAPS - 1);
  localparam logic [IDX_W-1:0]  LAST_SLOT = IDX_W'(NUM_SLOTS - 1);
  localparam logic [ADDR_W-1:0] LAST_RD   = ADDR_W'(NUM_READS - 1);
  localparam bit                NEED_PAD  = (NUM_SLOTS > NUM_TAPS);

  typedef enum logic [1:0] {W_IDLE, W_LOAD, W_PAD, W_DONE} wstate_e;
  typedef enum logic [2:0] {C_IDLE, C_WAIT, C_FETCH, C_LOOP, C_FLUSH, C_SUM, C_OUTPUT} cstate_e;

  wstate_e           w_q, w_d;
  cstate_e           c_q, c_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [MSEL_W-1:0] wmsel_q, wmsel_d;
  logic [ADDR_W-1:0] rd_q, rd_d;
  logic              bank_q, bank_d;
  logic              cvalid_q, cvalid_d;
  logic              ovr_q, ovr_d;
  logic [7:0]        ovr_cnt_q, ovr_cnt_d;
  logic              swap, wr_step, busy;

  always_ff @(posedge iClk) begin
    if (iRst) begin
      w_q       <= W_IDLE;
      c_q       <= C_IDLE;
      idx_q     <= '0;
      waddr_q   <= '0;
      wmsel_q   <= '0;
      rd_q      <= '0;
      bank_q    <= 1'b0;
      cvalid_q  <= 1'b0;
      ovr_q     <= 1'b0;
      ovr_cnt_q <= '0;
    end else begin
      w_q       <= w_d;
      c_q       <= c_d;
      idx_q     <= idx_d;
      waddr_q   <= waddr_d;
      wmsel_q   <= wmsel_d;
      rd_q      <= rd_d;
      bank_q    <= bank_d;
      cvalid_q  <= cvalid_d;
      ovr_q     <= ovr_d;
      ovr_cnt_q <= ovr_cnt_d;
    end
  end

  always_comb begin
    w_d = w_q;  c_d = c_q;  idx_d = idx_q;  waddr_d = waddr_q;  wmsel_d = wmsel_q;
    rd_d = rd_q;  bank_d = bank_q;  cvalid_d = cvalid_q;  ovr_cnt_d = ovr_cnt_q;
    wr_step     = 1'b0;
    oCoeffReady = 1'b0;
    oWrCsn      = 1'b1;
    oWrZero     = 1'b0;
    oRdCsn      = 1'b1;
    oRdAddr     = '0;
    oMacClr     = 1'b0;
    oMacEn      = 1'b0;
    oAccEn      = 1'b0;
    oEnOut      = 1'b0;
    busy        = (c_q != C_IDLE) && (c_q != C_WAIT);
    swap        = (w_q == W_DONE) && !busy;

    case (w_q)
      W_LOAD: begin
        oCoeffReady = 1'b1;
        oWrCsn      = ~iCoeffValid;
        if (iCoeffValid) begin
          wr_step = 1'b1;
          if (idx_q == LAST_TAP) w_d = NEED_PAD ? W_PAD : W_DONE;
        end
      end
      W_PAD: begin
        oWrCsn  = 1'b0;
        oWrZero = 1'b1;
        wr_step = 1'b1;
        if (idx_q == LAST_SLOT) w_d = W_DONE;
      end
      W_DONE: begin
        if (swap) begin
          w_d      = W_IDLE;
          bank_d   = ~bank_q;
          cvalid_d = 1'b1;
        end
      end
      default: ;
    endcase

    // Counters walk MAC-major: address wraps at NUM_READS, then the MAC select advances.
    if (wr_step) begin
      idx_d = idx_q + 1'b1;
      if (waddr_q == LAST_RD) begin
        waddr_d = '0;
        wmsel_d = wmsel_q + 1'b1;
      end else begin
        waddr_d = waddr_q + 1'b1;
      end
    end

    // A restart wins over everything except the swap already decided above.
    if (iUpdateFlag) begin
      w_d     = W_LOAD;
      idx_d   = '0;
      waddr_d = '0;
      wmsel_d = '0;
    end

    case (c_q)
      C_IDLE:  if (swap) c_d = C_WAIT;
      C_WAIT:  if (iEnSample) c_d = C_FETCH;
      C_FETCH: begin
        oRdCsn  = 1'b0;
        oMacClr = 1'b1;
        rd_d    = '0;
        c_d     = C_LOOP;
      end
      C_LOOP: begin
        oMacEn = 1'b1;
        if (rd_q != LAST_RD) begin
          oRdCsn  = 1'b0;
          oRdAddr = rd_q + 1'b1;
          rd_d    = rd_q + 1'b1;
        end else begin
          c_d = C_FLUSH;
        end
      end
      C_FLUSH:  c_d = C_SUM;
      C_SUM: begin
        oAccEn = 1'b1;
        c_d    = C_OUTPUT;
      end
      C_OUTPUT: begin
        oEnOut = 1'b1;
        c_d    = C_WAIT;
      end
      default: c_d = C_IDLE;
    endcase

    ovr_d = busy && iEnSample;
    if (ovr_d && (ovr_cnt_q != 8'hFF)) ovr_cnt_d = ovr_cnt_q + 8'd1;
  end

  assign oWrBank     = ~bank_q;
  assign oWrMacSel   = wmsel_q;
  assign oWrAddr     = waddr_q;
  assign oRdBank     = bank_q;
  assign oBusy       = busy;
  assign oCoeffValid = cvalid_q;
  assign oOverrun    = ovr_q;
  assign oOverrunCnt = ovr_cnt_q;

endmodule

// File: tb/tb_fir_ctrl_fsm_param.sv
// Directed bench for fir_ctrl_fsm_param: default 33-tap/3-MAC instance plus a 21-tap/2-MAC padding instance.
module tb_fir_ctrl_fsm_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  logic       rst, upd, cval, ens;
  logic       oCoeffReady, oWrCsn, oWrBank, oWrZero, oRdCsn, oRdBank;
  logic       oMacClr, oMacEn, oAccEn, oEnOut, oBusy, oCoeffValid, oOverrun;
  logic [1:0] oWrMacSel;
  logic [3:0] oWrAddr, oRdAddr;
  logic [7:0] oOverrunCnt;

  logic       b_rst, b_upd, b_cval, b_ens;
  logic       b_oCoeffReady, b_oWrCsn, b_oWrBank, b_oWrZero, b_oRdCsn, b_oRdBank;
  logic       b_oMacClr, b_oMacEn, b_oAccEn, b_oEnOut, b_oBusy, b_oCoeffValid, b_oOverrun;
  logic [0:0] b_oWrMacSel;
  logic [3:0] b_oWrAddr, b_oRdAddr;
  logic [7:0] b_oOverrunCnt;

  fir_ctrl_fsm_param #(.NUM_TAPS(33), .NUM_MAC(3), .ADDR_W(4)) dut (
    .iClk(clk), .iRst(rst), .iUpdateFlag(upd), .iCoeffValid(cval), .oCoeffReady(oCoeffReady),
    .iEnSample(ens), .oWrCsn(oWrCsn), .oWrBank(oWrBank), .oWrMacSel(oWrMacSel), .oWrAddr(oWrAddr),
    .oWrZero(oWrZero), .oRdCsn(oRdCsn), .oRdBank(oRdBank), .oRdAddr(oRdAddr), .oMacClr(oMacClr),
    .oMacEn(oMacEn), .oAccEn(oAccEn), .oEnOut(oEnOut), .oBusy(oBusy), .oCoeffValid(oCoeffValid),
    .oOverrun(oOverrun), .oOverrunCnt(oOverrunCnt)
  );

  fir_ctrl_fsm_param #(.NUM_TAPS(21), .NUM_MAC(2), .ADDR_W(4)) dut_pad (
    .iClk(clk), .iRst(b_rst), .iUpdateFlag(b_upd), .iCoeffValid(b_cval), .oCoeffReady(b_oCoeffReady),
    .iEnSample(b_ens), .oWrCsn(b_oWrCsn), .oWrBank(b_oWrBank), .oWrMacSel(b_oWrMacSel), .oWrAddr(b_oWrAddr),
    .oWrZero(b_oWrZero), .oRdCsn(b_oRdCsn), .oRdBank(b_oRdBank), .oRdAddr(b_oRdAddr), .oMacClr(b_oMacClr),
    .oMacEn(b_oMacEn), .oAccEn(b_oAccEn), .oEnOut(b_oEnOut), .oBusy(b_oBusy), .oCoeffValid(b_oCoeffValid),
    .oOverrun(b_oOverrun), .oOverrunCnt(b_oOverrunCnt)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; upd = 1'b0; cval = 1'b0; ens = 1'b0;
    b_rst = 1'b1; b_upd = 1'b0; b_cval = 1'b0; b_ens = 1'b0;
    tick(); tick();
    rst = 1'b0; b_rst = 1'b0;
    #2;
    n_chk++;
    if ({oWrCsn, oRdCsn, oWrBank} !== 3'b111) begin
      n_fail++; $display("FAIL reset_strobes got=%b want=111", {oWrCsn, oRdCsn, oWrBank});
    end
    n_chk++;
    if ({oCoeffReady, oWrZero, oMacClr, oMacEn, oAccEn, oEnOut, oBusy, oCoeffValid, oOverrun, oRdBank} !== 10'b0) begin
      n_fail++; $display("FAIL reset_flags got=%b want=0", {oCoeffReady, oWrZero, oMacClr, oMacEn, oAccEn,
                                                           oEnOut, oBusy, oCoeffValid, oOverrun, oRdBank});
    end
    n_chk++;
    if ({oWrMacSel, oWrAddr, oRdAddr, oOverrunCnt} !== 18'b0) begin
      n_fail++; $display("FAIL reset_buses got=%h want=0", {oWrMacSel, oWrAddr, oRdAddr, oOverrunCnt});
    end
    tick();
  endtask

  task automatic test_load;
    logic [1:0] em;
    logic [3:0] ea;
    ens = 1'b1; tick(); ens = 1'b0;
    #2;
    n_chk++;
    if ({oBusy, oOverrun} !== 2'b00) begin
      n_fail++; $display("FAIL idle_sample_ignored got=%b want=00", {oBusy, oOverrun});
    end
    upd = 1'b1; tick(); upd = 1'b0;
    cval = 1'b1;
    for (int i = 0; i < 33; i++) begin
      em = 2'(i / 11);
      ea = 4'(i % 11);
      #2;
      n_chk++;
      if ({oWrCsn, oWrMacSel, oWrAddr, oWrZero, oWrBank, oCoeffReady} !== {1'b0, em, ea, 1'b0, 1'b1, 1'b1}) begin
        n_fail++; $display("FAIL load_write[%0d] got csn=%b sel=%0d addr=%0d zero=%b bank=%b rdy=%b want csn=0 sel=%0d addr=%0d zero=0 bank=1 rdy=1",
                           i, oWrCsn, oWrMacSel, oWrAddr, oWrZero, oWrBank, oCoeffReady, em, ea);
      end
      tick();
    end
    cval = 1'b0;
    #2;
    n_chk++;
    if ({oWrCsn, oCoeffReady, oWrZero, oRdBank, oCoeffValid} !== 5'b10000) begin
      n_fail++; $display("FAIL load_done got=%b want=10000", {oWrCsn, oCoeffReady, oWrZero, oRdBank, oCoeffValid});
    end
    tick();
    #2;
    n_chk++;
    if ({oRdBank, oCoeffValid, oWrBank} !== 3'b110) begin
      n_fail++; $display("FAIL first_swap got=%b want=110", {oRdBank, oCoeffValid, oWrBank});
    end
  endtask

  task automatic test_sample;
    logic exp_csn;
    ens = 1'b1; tick(); ens = 1'b0;
    #2;
    n_chk++;
    if ({oBusy, oRdCsn, oRdAddr, oMacClr, oMacEn, oRdBank} !== {1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL fetch got busy=%b csn=%b addr=%0d clr=%b en=%b bank=%b want 1 0 0 1 0 1",
                         oBusy, oRdCsn, oRdAddr, oMacClr, oMacEn, oRdBank);
    end
    tick();
    for (int k = 0; k < 11; k++) begin
      exp_csn = (k < 10) ? 1'b0 : 1'b1;
      #2;
      n_chk++;
      if ({oMacEn, oRdCsn, oMacClr, oAccEn} !== {1'b1, exp_csn, 1'b0, 1'b0}) begin
        n_fail++; $display("FAIL loop_ctl[%0d] got en=%b csn=%b clr=%b acc=%b want 1 %b 0 0",
                           k, oMacEn, oRdCsn, oMacClr, oAccEn, exp_csn);
      end
      if (k < 10) begin
        n_chk++;
        if (oRdAddr !== 4'(k + 1)) begin
          n_fail++; $display("FAIL loop_addr[%0d] got=%0d want=%0d", k, oRdAddr, k + 1);
        end
      end
      tick();
    end
    #2;
    n_chk++;
    if ({oMacEn, oAccEn, oEnOut, oBusy} !== 4'b0001) begin
      n_fail++; $display("FAIL flush got=%b want=0001", {oMacEn, oAccEn, oEnOut, oBusy});
    end
    tick(); #2;
    n_chk++;
    if ({oMacEn, oAccEn, oEnOut, oBusy} !== 4'b0101) begin
      n_fail++; $display("FAIL sum_t14 got=%b want=0101", {oMacEn, oAccEn, oEnOut, oBusy});
    end
    tick(); #2;
    n_chk++;
    if ({oMacEn, oAccEn, oEnOut, oBusy} !== 4'b0011) begin
      n_fail++; $display("FAIL output_t15 got=%b want=0011", {oMacEn, oAccEn, oEnOut, oBusy});
    end
    tick(); #2;
    n_chk++;
    if ({oMacEn, oAccEn, oEnOut, oBusy} !== 4'b0000) begin
      n_fail++; $display("FAIL back_to_wait got=%b want=0000", {oMacEn, oAccEn, oEnOut, oBusy});
    end
  endtask

  task automatic test_overrun;
    int n_out;
    ens = 1'b1; tick(); ens = 1'b0;
    tick(); tick(); tick(); tick();
    ens = 1'b1; tick(); ens = 1'b0;
    #2;
    n_chk++;
    if ({oOverrun, oOverrunCnt} !== {1'b1, 8'd1}) begin
      n_fail++; $display("FAIL overrun_pulse got ovr=%b cnt=%0d want ovr=1 cnt=1", oOverrun, oOverrunCnt);
    end
    tick(); #2;
    n_chk++;
    if ({oOverrun, oOverrunCnt} !== {1'b0, 8'd1}) begin
      n_fail++; $display("FAIL overrun_one_cycle got ovr=%b cnt=%0d want ovr=0 cnt=1", oOverrun, oOverrunCnt);
    end
    n_out = 0;
    for (int c = 0; c < 20; c++) begin
      #2;
      if (oEnOut === 1'b1) n_out++;
      tick();
    end
    n_chk++;
    if (n_out !== 1) begin
      n_fail++; $display("FAIL overrun_single_output got=%0d want=1", n_out);
    end
  endtask

  task automatic test_swap_during_loop;
    int busy_n, bad;
    ens = 1'b1; tick(); ens = 1'b0;
    upd = 1'b1; tick(); upd = 1'b0;
    cval = 1'b1;
    busy_n = 0; bad = 0;
    for (int i = 0; i < 33; i++) begin
      #2;
      if (oBusy === 1'b1) begin
        busy_n++;
        if (oRdBank !== 1'b1) bad++;
      end
      if ({oWrCsn, oWrBank} !== 2'b00) bad++;
      tick();
    end
    cval = 1'b0;
    n_chk++;
    if (bad !== 0) begin
      n_fail++; $display("FAIL bank_stable_during_load got=%0d bad cycles want=0", bad);
    end
    n_chk++;
    if (busy_n !== 14) begin
      n_fail++; $display("FAIL busy_cycles_in_load got=%0d want=14", busy_n);
    end
    #2;
    n_chk++;
    if ({oRdBank, oCoeffReady, oWrCsn} !== 3'b101) begin
      n_fail++; $display("FAIL pending_swap got=%b want=101", {oRdBank, oCoeffReady, oWrCsn});
    end
    tick(); #2;
    n_chk++;
    if ({oRdBank, oWrBank, oCoeffValid} !== 3'b011) begin
      n_fail++; $display("FAIL swap_in_wait got=%b want=011", {oRdBank, oWrBank, oCoeffValid});
    end
    ens = 1'b1; tick(); ens = 1'b0;
    #2;
    n_chk++;
    if ({oBusy, oMacClr, oRdBank} !== 3'b110) begin
      n_fail++; $display("FAIL fetch_new_bank got=%b want=110", {oBusy, oMacClr, oRdBank});
    end
    for (int c = 0; c < 16; c++) tick();
  endtask

  task automatic test_pad;
    logic [0:0] em;
    logic [3:0] ea;
    int macen_n, en_at;
    b_upd = 1'b1; tick(); b_upd = 1'b0;
    b_cval = 1'b1;
    for (int i = 0; i < 21; i++) begin
      em = 1'(i / 11);
      ea = 4'(i % 11);
      #2;
      n_chk++;
      if ({b_oWrCsn, b_oWrMacSel, b_oWrAddr, b_oWrZero, b_oWrBank} !== {1'b0, em, ea, 1'b0, 1'b1}) begin
        n_fail++; $display("FAIL pad_load[%0d] got csn=%b sel=%0d addr=%0d zero=%b bank=%b want 0 %0d %0d 0 1",
                           i, b_oWrCsn, b_oWrMacSel, b_oWrAddr, b_oWrZero, b_oWrBank, em, ea);
      end
      tick();
    end
    b_cval = 1'b0;
    #2;
    n_chk++;
    if ({b_oWrCsn, b_oWrMacSel, b_oWrAddr, b_oWrZero, b_oCoeffReady} !== {1'b0, 1'b1, 4'd10, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL pad_write got csn=%b sel=%0d addr=%0d zero=%b rdy=%b want 0 1 10 1 0",
                         b_oWrCsn, b_oWrMacSel, b_oWrAddr, b_oWrZero, b_oCoeffReady);
    end
    tick(); #2;
    n_chk++;
    if ({b_oWrCsn, b_oWrZero} !== 2'b10) begin
      n_fail++; $display("FAIL pad_single got=%b want=10", {b_oWrCsn, b_oWrZero});
    end
    tick(); #2;
    n_chk++;
    if ({b_oRdBank, b_oCoeffValid} !== 2'b11) begin
      n_fail++; $display("FAIL pad_swap got=%b want=11", {b_oRdBank, b_oCoeffValid});
    end
    b_ens = 1'b1; tick(); b_ens = 1'b0;
    macen_n = 0; en_at = 0;
    for (int c = 1; c <= 20; c++) begin
      #2;
      if (b_oMacEn === 1'b1) macen_n++;
      if (b_oEnOut === 1'b1) en_at = c;
      tick();
    end
    n_chk++;
    if (macen_n !== 11) begin
      n_fail++; $display("FAIL pad_loop_len got=%0d want=11", macen_n);
    end
    n_chk++;
    if (en_at !== 15) begin
      n_fail++; $display("FAIL pad_latency got=%0d want=15", en_at);
    end
  endtask

  task automatic test_reset_loop;
    int act;
    ens = 1'b1; tick(); ens = 1'b0;
    tick(); tick(); tick();
    #2;
    n_chk++;
    if ({oMacEn, oBusy} !== 2'b11) begin
      n_fail++; $display("FAIL pre_reset_loop got=%b want=11", {oMacEn, oBusy});
    end
    rst = 1'b1; tick(); rst = 1'b0;
    #2;
    n_chk++;
    if ({oRdCsn, oWrCsn, oWrBank} !== 3'b111) begin
      n_fail++; $display("FAIL midloop_reset_strobes got=%b want=111", {oRdCsn, oWrCsn, oWrBank});
    end
    n_chk++;
    if ({oMacEn, oBusy, oCoeffValid, oRdBank, oMacClr, oAccEn, oEnOut, oOverrun, oOverrunCnt} !== 16'b0) begin
      n_fail++; $display("FAIL midloop_reset_state got=%b want=0",
                         {oMacEn, oBusy, oCoeffValid, oRdBank, oMacClr, oAccEn, oEnOut, oOverrun, oOverrunCnt});
    end
    ens = 1'b1; tick(); ens = 1'b0;
    act = 0;
    for (int c = 0; c < 20; c++) begin
      #2;
      if ((oBusy | oEnOut | oMacEn | oOverrun) === 1'b1) act++;
      tick();
    end
    n_chk++;
    if (act !== 0) begin
      n_fail++; $display("FAIL sample_ignored_after_reset got=%0d active cycles want=0", act);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_sample();
    test_overrun();
    test_swap_during_loop();
    test_pad();
    test_reset_loop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
